// File: rtl/prog_fsm_4s2i1o_ctrl_if.sv
// Configuration, symbol-handshake and status bundle for the programmable
// 4-state, 2-bit-input, 1-output FSM controller.
interface prog_fsm_4s2i1o_ctrl_if;
  logic       cfg_en;
  logic [3:0] cfg_addr;
  logic [1:0] cfg_next;
  logic       cfg_out_en;
  logic [1:0] cfg_out_addr;
  logic       cfg_out_val;
  logic       in_valid;
  logic [1:0] in_;
  logic       in_ready;
  logic [1:0] state;
  logic       out;
  logic [7:0] count;

  modport master (
    output cfg_en, cfg_addr, cfg_next, cfg_out_en, cfg_out_addr, cfg_out_val,
    output in_valid, in_,
    input  in_ready, state, out, count
  );

  modport slave (
    input  cfg_en, cfg_addr, cfg_next, cfg_out_en, cfg_out_addr, cfg_out_val,
    input  in_valid, in_,
    output in_ready, state, out, count
  );
endinterface

// File: rtl/prog_fsm_4s2i1o_ctrl.sv
// Programmable Moore FSM: RAM-style next-state and output tables, a
// registered state and a saturating count of accepted input symbols.
module prog_fsm_4s2i1o_ctrl (
  input  logic                      clk,
  input  logic                      reset,
  prog_fsm_4s2i1o_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

  // Default next-state entry for {s, i} is i: every state jumps to the symbol.
  localparam logic [15:0][1:0] NS_RESET  = {4{8'hE4}};
  localparam logic [3:0]       OUT_RESET = 4'b1000;

  logic [15:0][1:0] ns_tbl_q, ns_tbl_d;
  logic [3:0]       out_tbl_q, out_tbl_d;
  state_t           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic             accept;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign accept = bus.in_valid && !bus.cfg_en;

  always_comb begin
    ns_tbl_d  = ns_tbl_q;
    out_tbl_d = out_tbl_q;
    state_d   = state_q;
    count_d   = count_q;
    if (bus.cfg_en) begin
      ns_tbl_d[bus.cfg_addr] = bus.cfg_next;
    end
    if (bus.cfg_out_en) begin
      out_tbl_d[bus.cfg_out_addr] = bus.cfg_out_val;
    end
    if (accept) begin
      state_d = state_t'(ns_tbl_q[{state_q, bus.in_}]);
      count_d = sat_inc(count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ns_tbl_q  <= NS_RESET;
      out_tbl_q <= OUT_RESET;
      state_q   <= S0;
      count_q   <= 8'd0;
    end else begin
      ns_tbl_q  <= ns_tbl_d;
      out_tbl_q <= out_tbl_d;
      state_q   <= state_d;
      count_q   <= count_d;
    end
  end

  assign bus.in_ready = ~bus.cfg_en;
  assign bus.state    = state_q;
  assign bus.out      = out_tbl_q[state_q];
  assign bus.count    = count_q;

endmodule

// File: tb/tb_prog_fsm_4s2i1o_ctrl.sv
// Directed and randomized bench for prog_fsm_4s2i1o_ctrl against a
// table-level behavioural model.
module tb_prog_fsm_4s2i1o_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  prog_fsm_4s2i1o_ctrl_if bif ();

  prog_fsm_4s2i1o_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain arrays indexed by state*4 + symbol.
  int m_tbl [16];
  int m_out [4];
  int m_state;
  int m_count;
  int r_tbl [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_tbl[k] = k % 4;
    m_out[0] = 0; m_out[1] = 0; m_out[2] = 0; m_out[3] = 1;
    m_state = 0;
    m_count = 0;
  endtask

  // One clock: drive inputs, check combinational outputs, clock, update model, check registers.
  task automatic cyc(input bit ce, input int ca, input int cn,
                     input bit oe, input int oa, input bit ov,
                     input bit v, input int sym, input bit r, input string tag);
    int nxt;
    bit acc;
    bif.cfg_en       = ce;
    bif.cfg_addr     = 4'(ca);
    bif.cfg_next     = 2'(cn);
    bif.cfg_out_en   = oe;
    bif.cfg_out_addr = 2'(oa);
    bif.cfg_out_val  = ov;
    bif.in_valid     = v;
    bif.in_          = 2'(sym);
    reset            = r;
    #1;
    chk({tag, ".in_ready"}, 32'(bif.in_ready), 32'(!ce));
    chk({tag, ".out_pre"},  32'(bif.out),      32'(m_out[m_state]));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      acc = v && !ce;
      nxt = m_tbl[m_state * 4 + sym];
      if (ce) m_tbl[ca] = cn;
      if (oe) m_out[oa] = ov;
      if (acc) begin
        m_state = nxt;
        m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
      end
    end
    #1;
    chk({tag, ".state"}, 32'(bif.state), 32'(m_state));
    chk({tag, ".out"},   32'(bif.out),   32'(m_out[m_state]));
    chk({tag, ".count"}, 32'(bif.count), 32'(m_count));
  endtask

  task automatic accept(input int sym, input string tag);
    cyc(0, 0, 0, 0, 0, 0, 1, sym, 0, tag);
  endtask

  task automatic wr_tbl(input int a, input int n, input string tag);
    cyc(1, a, n, 0, 0, 0, 1, $urandom_range(0, 3), 0, tag);
  endtask

  task automatic do_reset(input string tag);
    cyc(bit'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
        1, $urandom_range(0, 3), 1, 1, $urandom_range(0, 3), 1, tag);
  endtask

  initial begin
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, "init_reset");
    // Fixed expectations for the reset state, independent of the model.
    chk("rst.state", 32'(bif.state), 0);
    chk("rst.count", 32'(bif.count), 0);
    chk("rst.out",   32'(bif.out),   0);

    // Default table: accept 3,1,2,3.
    accept(3, "dflt3"); chk("dflt3.out_c", 32'(bif.out), 1);
    accept(1, "dflt1"); chk("dflt1.out_c", 32'(bif.out), 0);
    accept(2, "dflt2"); chk("dflt2.out_c", 32'(bif.out), 0);
    accept(3, "dflt3b");
    chk("dflt.state_c", 32'(bif.state), 3);
    chk("dflt.count_c", 32'(bif.count), 4);

    // Write table[{0,0}]=2 while in_valid=1 is blocked, then step.
    do_reset("r034");
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 0, "cfg_block");
    chk("cfg_block.state_c", 32'(bif.state), 0);
    chk("cfg_block.count_c", 32'(bif.count), 0);
    accept(0, "after_cfg");
    chk("after_cfg.state_c", 32'(bif.state), 2);

    // Output-table writes, including one landing with a step in the same cycle.
    do_reset("r035");
    cyc(0, 0, 0, 1, 1, 1, 0, 0, 0, "wr_out1");
    accept(1, "to_s1");
    chk("to_s1.out_c", 32'(bif.out), 1);
    cyc(0, 0, 0, 1, 2, 1, 1, 2, 0, "wr_out2_step");
    chk("wr_out2_step.out_c", 32'(bif.out), 1);
    chk("wr_out2_step.state_c", 32'(bif.state), 2);
    // Both config enables together.
    cyc(1, 9, 0, 1, 0, 1, 1, 3, 0, "both_cfg");
    accept(1, "both_cfg_use");
    chk("both_cfg_use.state_c", 32'(bif.state), 0);
    chk("both_cfg_use.out_c", 32'(bif.out), 1);

    // Saturation: 300 continuous accepts.
    do_reset("r036");
    for (int k = 0; k < 300; k++) accept($urandom_range(0, 3), "sat");
    chk("sat.count_c", 32'(bif.count), 255);

    // Custom table, reach state 2 with count 5, then reset restores defaults.
    do_reset("r037");
    for (int k = 0; k < 16; k++) wr_tbl(k, 2, "prog2");
    for (int k = 0; k < 5; k++) accept($urandom_range(0, 3), "run5");
    chk("run5.state_c", 32'(bif.state), 2);
    chk("run5.count_c", 32'(bif.count), 5);
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 1, "mid_reset");
    accept(1, "post_reset");
    chk("post_reset.state_c", 32'(bif.state), 1);
    chk("post_reset.out_c", 32'(bif.out), 0);

    // Exhaustive sweep over a random table.
    do_reset("r038");
    for (int k = 0; k < 16; k++) begin
      r_tbl[k] = $urandom_range(0, 3);
      wr_tbl(k, r_tbl[k], "rand_tbl");
    end
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, k, bit'($urandom_range(0, 1)), 0, 0, 0, "rand_out");
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) begin
        int old;
        old = m_state;
        wr_tbl(old * 4, s, "steer");
        accept(0, "steer_go");
        wr_tbl(old * 4, r_tbl[old * 4], "restore");
        accept(i, "sweep");
      end
    end

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      cyc(bit'($urandom_range(0, 3) == 0), $urandom_range(0, 15), $urandom_range(0, 3),
          bit'($urandom_range(0, 2) == 0), $urandom_range(0, 3), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
          bit'($urandom_range(0, 40) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
